// File: rtl/matrix_stream_tx.sv
// Streams one captured 8-bit matrix (up to 5x5) out of a packed 400-bit two-slot bus,
// element by element in row-major order with valid/ready handshaking.
module matrix_stream_tx (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mat_sel,
    input  logic [2:0]   rows,
    input  logic [2:0]   cols,
    input  logic [399:0] matrices_in,
    input  logic         out_ready,
    input  logic         abort,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic [2:0]   out_row,
    output logic [2:0]   out_col,
    output logic         out_eol,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         err
);
    // state | meaning
    // IDLE  | waiting for start; outputs held at zero
    // SEND  | presenting captured elements, advancing on each accepted transfer
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t       state, state_nxt;
    logic [199:0] slot_q;
    logic [2:0]   rows_q, cols_q;
    logic [2:0]   row_q, col_q;
    logic         err_q;

    logic         dims_ok, accept, xfer, at_eol, at_last;
    logic [4:0]   elem_idx;
    logic [7:0]   elem_data;

    assign dims_ok  = (rows != 3'd0) && (rows <= 3'd5) && (cols != 3'd0) && (cols <= 3'd5);
    assign accept   = (state == IDLE) && start && dims_ok;
    // abort wins over a transfer offered in the same cycle
    assign xfer     = (state == SEND) && out_ready && !abort;
    assign at_eol   = (col_q == cols_q - 3'd1);
    assign at_last  = at_eol && (row_q == rows_q - 3'd1);
    assign elem_idx = 5'(row_q) * 5'd5 + 5'(col_q);

    always_comb begin
        elem_data = 8'd0;
        for (int i = 0; i < 25; i++) begin
            if (elem_idx == 5'(i)) elem_data = slot_q[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: begin
                if (abort)               state_nxt = IDLE;
                else if (xfer && at_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
            rows_q <= 3'd0;
            cols_q <= 3'd0;
            row_q  <= 3'd0;
            col_q  <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && !dims_ok;
            if (accept) begin
                slot_q <= mat_sel ? matrices_in[399:200] : matrices_in[199:0];
                rows_q <= rows;
                cols_q <= cols;
            end
            if (state != SEND) begin
                row_q <= 3'd0;
                col_q <= 3'd0;
            end else if (xfer) begin
                if (at_eol) begin
                    col_q <= 3'd0;
                    row_q <= row_q + 3'd1;
                end else begin
                    col_q <= col_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        busy      = (state == SEND);
        done      = (state == DONE);
        err       = err_q;
        out_valid = busy;
        out_data  = 8'd0;
        out_row   = 3'd0;
        out_col   = 3'd0;
        out_eol   = 1'b0;
        out_last  = 1'b0;
        if (busy) begin
            out_data = elem_data;
            out_row  = row_q;
            out_col  = col_q;
            out_eol  = at_eol;
            out_last = at_last;
        end
    end
endmodule

// File: tb/tb_matrix_stream_tx.sv
// Self-checking bench for matrix_stream_tx: table of stream scenarios plus randomized
// streams, compared against a row-major element list built from the packed-bus layout.
module tb_matrix_stream_tx;
    logic         clk = 1'b0;
    logic         reset, start, mat_sel, out_ready, abort;
    logic [2:0]   rows, cols;
    logic [399:0] matrices_in;
    logic         out_valid, out_eol, out_last, busy, done, err;
    logic [7:0]   out_data;
    logic [2:0]   out_row, out_col;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       eol;
        logic       last;
    } elem_t;

    typedef struct {
        int nr;
        int nc;
        int sel;
        int rmode;
        int fill;
        int abort_after;
        bit overwrite;
        bit exp_err;
        int exp_xfers;
    } vec_t;

    int           checks = 0;
    int           failures = 0;
    logic [399:0] mat_buf;
    vec_t         vecs[$];

    always #5 clk = ~clk;

    matrix_stream_tx dut (
        .clk(clk), .reset(reset), .start(start), .mat_sel(mat_sel),
        .rows(rows), .cols(cols), .matrices_in(matrices_in),
        .out_ready(out_ready), .abort(abort),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({out_valid, out_data, out_row, out_col, out_eol, out_last, busy, done, err});
    endfunction

    task automatic put(input int s, input int r, input int c, input logic [7:0] v);
        mat_buf[s*200 + (r*5 + c)*8 +: 8] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 50; i++) mat_buf[i*8 +: 8] = 8'($urandom);
    endtask

    task automatic run_stream(input int nr, input int nc, input int sel, input int rmode,
                              input int abort_after, input bit overwrite,
                              input bit exp_err, input int exp_xfers);
        elem_t exp_q[$];
        elem_t got, held;
        int    n_got, cycles, ph;
        bit    stalled, finished;

        exp_q = {};
        if (!exp_err) begin
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c++)
                    exp_q.push_back('{data: mat_buf[sel*200 + (r*5 + c)*8 +: 8],
                                      row: 3'(r), col: 3'(c),
                                      eol: (c == nc - 1),
                                      last: (r == nr - 1) && (c == nc - 1)});
        end

        @(negedge clk);
        matrices_in = mat_buf;
        rows        = 3'(nr);
        cols        = 3'(nc);
        mat_sel     = sel[0];
        out_ready   = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;

        if (exp_err) begin
            check("err_pulse", 32'(err), 1);
            check("err_no_valid", 32'(out_valid), 0);
            check("err_busy", 32'(busy), 0);
            @(negedge clk);
            check("err_one_cycle", 32'(err), 0);
            check("err_still_idle", 32'({out_valid, busy}), 0);
            return;
        end

        check("no_err_on_start", 32'(err), 0);
        if (overwrite) begin
            matrices_in = '1;
            rows        = 3'd0;
            cols        = 3'd7;
            mat_sel     = ~mat_sel;
            start       = 1'b1;
        end

        n_got = 0; cycles = 0; ph = 0; stalled = 1'b0; finished = 1'b0;
        while (!finished && cycles < 400) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            cycles++;
            check("valid_in_send", 32'(out_valid), 1);
            check("busy_in_send", 32'(busy), 1);
            check("no_err_in_send", 32'(err), 0);
            got = {out_data, out_row, out_col, out_eol, out_last};
            if (stalled) check("stall_stable", 32'(got), 32'(held));

            if (abort_after >= 0 && n_got == abort_after) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                start     = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid_low", 32'(out_valid), 0);
                check("abort_no_done", 32'(done), 0);
                check("abort_busy_low", 32'(busy), 0);
                @(negedge clk);
                check("abort_no_late_done", 32'(done), 0);
                check("abort_xfer_count", 32'(n_got), 32'(exp_xfers));
                return;
            end

            if (out_ready) begin
                check($sformatf("elem_%0d", n_got), 32'(got), 32'(exp_q[n_got]));
                n_got++;
                stalled = 1'b0;
                if (n_got == exp_q.size()) begin
                    finished = 1'b1;
                    start    = 1'b0;
                end
            end else begin
                stalled = 1'b1;
                held    = got;
            end
            @(negedge clk);
        end

        start     = 1'b0;
        out_ready = 1'b0;
        if (!finished) begin
            check("stream_timeout", 32'(n_got), 32'(exp_q.size()));
            return;
        end
        check("xfer_count", 32'(n_got), 32'(exp_xfers));
        if (rmode == 0) check("back_to_back_cycles", 32'(cycles), 32'(exp_xfers));
        check("done_pulse", 32'(done), 1);
        check("valid_low_after_last", 32'(out_valid), 0);
        check("busy_low_in_done", 32'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("idle_outputs_zero", all_outs(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; mat_sel = 1'b0; out_ready = 1'b0; abort = 1'b0;
        rows = 3'd0; cols = 3'd0; matrices_in = '0; mat_buf = '0;
        #1;
        check("reset_state", all_outs(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 0);

        // nr nc sel rmode fill abort overwrite exp_err exp_xfers
        vecs.push_back('{2, 2, 0, 0, 1, -1, 1'b0, 1'b0, 4});
        vecs.push_back('{2, 3, 1, 1, 2, -1, 1'b0, 1'b0, 6});
        vecs.push_back('{0, 3, 0, 0, 0, -1, 1'b0, 1'b1, 0});
        vecs.push_back('{3, 6, 1, 0, 0, -1, 1'b0, 1'b1, 0});
        vecs.push_back('{1, 1, 0, 0, 0, -1, 1'b0, 1'b0, 1});
        vecs.push_back('{5, 5, 1, 0, 0, -1, 1'b0, 1'b0, 25});
        vecs.push_back('{5, 5, 0, 2, 0, -1, 1'b1, 1'b0, 25});
        vecs.push_back('{5, 5, 0, 0, 0, 2, 1'b0, 1'b0, 2});
        vecs.push_back('{3, 4, 1, 2, 0, -1, 1'b0, 1'b0, 12});
        vecs.push_back('{7, 2, 0, 0, 0, -1, 1'b0, 1'b1, 0});
        vecs.push_back('{4, 1, 0, 1, 0, -1, 1'b0, 1'b0, 4});
        vecs.push_back('{1, 5, 1, 0, 0, -1, 1'b0, 1'b0, 5});

        foreach (vecs[i]) begin
            fill_random();
            if (vecs[i].fill == 1) begin
                put(0, 0, 0, 8'd14); put(0, 0, 1, 8'd8);
                put(0, 1, 0, 8'd26); put(0, 1, 1, 8'd14);
            end else if (vecs[i].fill == 2) begin
                put(1, 0, 0, 8'd1); put(1, 0, 1, 8'd2); put(1, 0, 2, 8'd3);
                put(1, 1, 0, 8'd3); put(1, 1, 1, 8'd4); put(1, 1, 2, 8'd5);
            end
            run_stream(vecs[i].nr, vecs[i].nc, vecs[i].sel, vecs[i].rmode,
                       vecs[i].abort_after, vecs[i].overwrite,
                       vecs[i].exp_err, vecs[i].exp_xfers);
        end

        for (int k = 0; k < 8; k++) begin
            int nr, nc;
            nr = $urandom_range(1, 5);
            nc = $urandom_range(1, 5);
            fill_random();
            run_stream(nr, nc, $urandom_range(0, 1), 2, -1, 1'($urandom_range(0, 1)),
                       1'b0, nr * nc);
        end

        // reset dropped in the middle of a stream
        fill_random();
        @(negedge clk);
        matrices_in = mat_buf; rows = 3'd3; cols = 3'd3; mat_sel = 1'b1;
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_stream_outputs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_reset_idle", all_outs(), 0);
        fill_random();
        run_stream(3, 3, 1, 0, -1, 1'b0, 1'b0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_stream_tx.md
MATRIX_STREAM_TX -- requirements
Module: matrix_stream_tx

Interface
REQ-001 The block SHALL be `matrix_stream_tx`: it unloads one 8-bit matrix from the packed 400-bit matrix bus and streams it out element by element in row-major order.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a transfer; SHALL be sampled only in IDLE.
REQ-005 mat_sel  input  1  slot select: 0 = bits [199:0], 1 = bits [399:200].
REQ-006 rows  input  3  matrix row count; legal range 1..5.
REQ-007 cols  input  3  matrix column count; legal range 1..5.
REQ-008 matrices_in  input  400  packed bus: element (r,c) of slot s SHALL be at bit s*200 + (r*5+c)*8, 8 bits wide.
REQ-009 out_ready  input  1  downstream accepts the current element.
REQ-010 abort  input  1  synchronous cancel of the current transfer.
REQ-011 out_valid  output  1  out_data holds a valid element.
REQ-012 out_data  output  8  element value.
REQ-013 out_row  output  3  row index of out_data.
REQ-014 out_col  output  3  column index of out_data.
REQ-015 out_eol  output  1  current element is the last element of its row.
REQ-016 out_last  output  1  current element is the final element of the matrix.
REQ-017 busy  output  1  block is high in SEND.
REQ-018 done  output  1  one-cycle pulse after the final transfer.
REQ-019 err  output  1  one-cycle pulse when start is rejected because of illegal dimensions.

Function
REQ-020 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-021 IDLE with start=1 and legal rows/cols:
- Capture the selected 200-bit slot, rows and cols into internal registers.
- Go to SEND.
- out_valid SHALL be 1 on the next cycle, with element (0,0).
REQ-022 IDLE with start=1 and rows or cols equal to 0 or greater than 5: pulse err for one cycle, stay in IDLE, capture nothing.
REQ-023 A transfer SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-024 After a transfer, the column index SHALL advance; at col = cols-1 it SHALL wrap to 0 and the row index SHALL advance.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_eol and out_last SHALL stay stable.
REQ-026 out_valid SHALL stay high back-to-back, so a continuously ready sink receives one element per cycle.
REQ-027 out_eol SHALL be 1 exactly when out_col = cols-1.
REQ-028 out_last SHALL be 1 exactly when out_row = rows-1 and out_col = cols-1.
REQ-029 The transfer with out_last=1 SHALL move SEND to DONE; the next cycle SHALL have out_valid=0.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-031 start SHALL be ignored in SEND and DONE.
REQ-032 Changes to matrices_in, rows, cols or mat_sel after capture SHALL NOT affect the stream in progress.
REQ-033 abort=1 in SEND SHALL return to IDLE on the next edge, with out_valid=0 and no done pulse; abort has priority over a coincident transfer.
REQ-034 abort SHALL be ignored in IDLE and DONE.
REQ-035 A 1x1 matrix SHALL emit one element with out_eol=1 and out_last=1.
REQ-036 In IDLE, out_valid, out_eol, out_last and busy SHALL be 0; out_data, out_row and out_col SHALL be 0.

Reset
REQ-037 reset=0 SHALL immediately force: state IDLE; out_valid, busy, done, err, out_eol, out_last = 0; out_data, out_row, out_col and the capture registers = 0.
REQ-038 Reset asserted mid-transfer SHALL abandon the stream; after release the block SHALL accept a new start normally.

Verification
REQ-039 2x2 stream:
- Stimulus: slot 0 = {14,8;26,14}, rows=2, cols=2, mat_sel=0, out_ready held 1, start pulsed.
- Response: data 14,8,26,14 on 4 consecutive cycles; eol on elements 2 and 4; last on element 4; done one cycle later.
REQ-040 Backpressure:
- Stimulus: 2x3 matrix {1,2,3;3,4,5} from slot 1, out_ready toggled 1,0,0,1,...
- Response: every element delivered exactly once, in order; outputs stable through each stall.
REQ-041 Illegal dimensions:
- Stimulus: rows=0 or cols=6, start pulsed.
- Response: err=1 for one cycle, out_valid never asserted, busy=0.
REQ-042 Snapshot:
- Stimulus: after start, overwrite matrices_in with all 0xFF.
- Response: the original values are still streamed.
REQ-043 Abort and reset:
- Stimulus 1: abort after 2 transfers of a 5x5 matrix. Response: out_valid=0 next cycle, no done; a following start streams correctly.
- Stimulus 2: reset=0 mid-stream. Response: all outputs 0 immediately.
REQ-044 Edge cases:
- Stimulus 1: 1x1 matrix. Response: one element, with eol=1 and last=1.
- Stimulus 2: 5x5 matrix. Response: 25 elements; element (4,4) taken from bits [199:192] of the selected slot.
